// File: rtl/fetch_unit.sv
// PC generation and single-outstanding I-cache fetch feeding the branch predictor,
// with a small fetch queue of {pc, inst, pred_pc} in front of decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        icache_req_valid,
  input  logic        icache_req_ready,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_inst,
  output logic [31:0] bp_pc,
  output logic [31:0] bp_inst,
  input  logic [31:0] bp_next_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fq_valid,
  input  logic        fq_ready,
  output logic [31:0] fq_pc,
  output logic [31:0] fq_inst,
  output logic [31:0] fq_pred_pc
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_STALL, ST_DROP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc_reg, inflight_pc;
  logic            run;
  logic [CW-1:0]   count, count_nxt;
  logic [PW-1:0]   head, tail;
  logic [31:0]     q_pc   [FQ_DEPTH];
  logic [31:0]     q_inst [FQ_DEPTH];
  logic [31:0]     q_pred [FQ_DEPTH];
  logic            hs, push, pop, room;
  logic [31:0]     next_pc_al;

  // run holds the request off until the first edge after reset release
  assign icache_req_valid = run && (state == ST_REQ);
  assign icache_req_addr  = pc_reg;
  assign bp_pc            = inflight_pc;
  assign bp_inst          = icache_resp_inst;
  assign next_pc_al       = bp_next_pc & ~32'h3;

  assign fq_valid   = (count != '0);
  assign fq_pc      = fq_valid ? q_pc[head]   : '0;
  assign fq_inst    = fq_valid ? q_inst[head] : '0;
  assign fq_pred_pc = fq_valid ? q_pred[head] : '0;

  always_comb begin
    hs        = icache_req_valid && icache_req_ready;
    push      = (state == ST_WAIT) && icache_resp_valid && !redirect_valid;
    pop       = fq_valid && fq_ready && !redirect_valid;
    count_nxt = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));
    room      = (count_nxt < CW'(FQ_DEPTH));
    state_nxt = state;
    if (redirect_valid) begin
      case (state)
        ST_REQ:   state_nxt = hs ? ST_DROP : ST_REQ;
        ST_WAIT:  state_nxt = icache_resp_valid ? ST_REQ : ST_DROP;
        ST_STALL: state_nxt = ST_REQ;
        ST_DROP:  state_nxt = icache_resp_valid ? ST_REQ : ST_DROP;
        default:  state_nxt = ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ:   if (hs) state_nxt = ST_WAIT;
        ST_WAIT:  if (icache_resp_valid) state_nxt = room ? ST_REQ : ST_STALL;
        ST_STALL: if (room) state_nxt = ST_REQ;
        ST_DROP:  if (icache_resp_valid) state_nxt = room ? ST_REQ : ST_STALL;
        default:  state_nxt = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_REQ;
      run         <= 1'b0;
      pc_reg      <= RESET_PC;
      inflight_pc <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      count <= count_nxt;
      if (hs) inflight_pc <= pc_reg;
      if (redirect_valid) begin
        pc_reg <= redirect_pc & ~32'h3;
        head   <= '0;
        tail   <= '0;
      end else begin
        if (push) begin
          pc_reg <= next_pc_al;
          tail   <= tail + PW'(1);
        end
        if (pop) head <= head + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= inflight_pc;
      q_inst[tail] <= icache_resp_inst;
      q_pred[tail] <= next_pc_al;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, taken prediction, backpressure,
// redirects (in WAIT, coincident with response and pop, unaligned) and mid-fetch reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        icache_req_valid, icache_req_ready;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_inst;
  logic [31:0] bp_pc, bp_inst, bp_next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_valid, fq_ready;
  logic [31:0] fq_pc, fq_inst, fq_pred_pc;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        outstanding = 1'b0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .FQ_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr),
    .icache_resp_valid(icache_resp_valid), .icache_resp_inst(icache_resp_inst),
    .bp_pc(bp_pc), .bp_inst(bp_inst), .bp_next_pc(bp_next_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fq_valid(fq_valid), .fq_ready(fq_ready),
    .fq_pc(fq_pc), .fq_inst(fq_inst), .fq_pred_pc(fq_pred_pc)
  );

  always #5 clk = ~clk;

  // A response is only legal while a request is outstanding
  always @(posedge clk) begin
    if (resetn && icache_resp_valid)
      assert (outstanding) else $error("response with no request outstanding");
    if (!resetn || icache_resp_valid) outstanding <= 1'b0;
    else if (icache_req_valid && icache_req_ready) outstanding <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic [31:0] pred);
    check_eq({tag, "_valid"}, {31'd0, fq_valid}, 32'd1);
    check_eq({tag, "_pc"},   fq_pc,      pc);
    check_eq({tag, "_inst"}, fq_inst,    inst);
    check_eq({tag, "_pred"}, fq_pred_pc, pred);
  endtask

  // Issue one request at exp_addr and answer it the following cycle
  task automatic fetch(input string tag, input logic [31:0] exp_addr,
                       input logic [31:0] inst, input logic [31:0] next);
    icache_req_ready = 1'b1;
    check_eq({tag, "_reqv"}, {31'd0, icache_req_valid}, 32'd1);
    check_eq({tag, "_addr"}, icache_req_addr, exp_addr);
    tick();
    check_eq({tag, "_wait_reqv"}, {31'd0, icache_req_valid}, 32'd0);
    icache_resp_valid = 1'b1;
    icache_resp_inst  = inst;
    bp_next_pc        = next;
    check_eq({tag, "_bp_pc"},   bp_pc,   exp_addr);
    check_eq({tag, "_bp_inst"}, bp_inst, inst);
    tick();
    icache_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; icache_req_ready = 1'b0; icache_resp_valid = 1'b0;
    icache_resp_inst = '0; bp_next_pc = '0; redirect_valid = 1'b0;
    redirect_pc = '0; fq_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_reqv", {31'd0, icache_req_valid}, 32'd0);
    check_eq("rst_fqv",  {31'd0, fq_valid}, 32'd0);
    check_eq("rst_addr", icache_req_addr, 32'h100);
    check_eq("rst_bppc", bp_pc, 32'h0);
    check_eq("rst_fqpc", fq_pc, 32'h0);
    resetn = 1'b1;
    icache_req_ready = 1'b1;
    check_eq("rel_reqv", {31'd0, icache_req_valid}, 32'd0);
    tick();

    // Sequential then taken prediction, queue held full
    fetch("f0", 32'h100, 32'hA000_0000, 32'h104);
    check_head("q0", 32'h100, 32'hA000_0000, 32'h104);
    fetch("f1", 32'h104, 32'hA000_0001, 32'h200);
    fetch("f2", 32'h200, 32'hA000_0002, 32'h204);
    fetch("f3", 32'h204, 32'hA000_0003, 32'h208);
    check_eq("stall_reqv", {31'd0, icache_req_valid}, 32'd0);
    tick();
    check_eq("stall_hold", {31'd0, icache_req_valid}, 32'd0);
    check_head("full_head", 32'h100, 32'hA000_0000, 32'h104);

    // One pop frees a slot; then drain in order
    fq_ready = 1'b1;
    icache_req_ready = 1'b0;
    tick();
    check_eq("unstall_reqv", {31'd0, icache_req_valid}, 32'd1);
    check_eq("unstall_addr", icache_req_addr, 32'h208);
    check_head("pop1", 32'h104, 32'hA000_0001, 32'h200);
    tick();
    check_head("pop2", 32'h200, 32'hA000_0002, 32'h204);
    tick();
    check_head("pop3", 32'h204, 32'hA000_0003, 32'h208);
    tick();
    check_eq("drained", {31'd0, fq_valid}, 32'd0);

    // Redirect during WAIT flushes queue and drops the stale response
    fq_ready = 1'b0;
    fetch("f4", 32'h208, 32'hA000_0004, 32'h20C);
    check_eq("f4_next", icache_req_addr, 32'h20C);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    check_eq("rd_flush", {31'd0, fq_valid}, 32'd0);
    check_eq("rd_reqv",  {31'd0, icache_req_valid}, 32'd0);
    icache_resp_valid = 1'b1; icache_resp_inst = 32'hDEAD_0000; bp_next_pc = 32'h998;
    tick();
    icache_resp_valid = 1'b0;
    check_eq("drop_nopush", {31'd0, fq_valid}, 32'd0);
    check_eq("drop_reqv",   {31'd0, icache_req_valid}, 32'd1);
    check_eq("drop_addr",   icache_req_addr, 32'h400);

    // Redirect coincident with response and pop
    fetch("f5", 32'h400, 32'hA000_0005, 32'h404);
    tick();
    icache_resp_valid = 1'b1; icache_resp_inst = 32'hDEAD_0001; bp_next_pc = 32'h604;
    redirect_valid = 1'b1; redirect_pc = 32'h500; fq_ready = 1'b1;
    tick();
    icache_resp_valid = 1'b0; redirect_valid = 1'b0; icache_req_ready = 1'b0;
    check_eq("co_fqv",  {31'd0, fq_valid}, 32'd0);
    check_eq("co_reqv", {31'd0, icache_req_valid}, 32'd1);
    check_eq("co_addr", icache_req_addr, 32'h500);
    tick();
    check_eq("co_nopush", {31'd0, fq_valid}, 32'd0);

    // Unaligned redirect and prediction are word-aligned
    redirect_valid = 1'b1; redirect_pc = 32'h503;
    tick();
    redirect_valid = 1'b0; fq_ready = 1'b0;
    fetch("f6", 32'h500, 32'hA000_0006, 32'h207);
    check_head("odd_q", 32'h500, 32'hA000_0006, 32'h204);
    check_eq("odd_addr", icache_req_addr, 32'h204);

    // Reset in WAIT returns outputs to reset values immediately
    tick();
    check_eq("pre_rst_bppc", bp_pc, 32'h204);
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_reqv", {31'd0, icache_req_valid}, 32'd0);
    check_eq("mid_rst_fqv",  {31'd0, fq_valid}, 32'd0);
    check_eq("mid_rst_bppc", bp_pc, 32'h0);
    check_eq("mid_rst_fqpc", fq_pc, 32'h0);
    check_eq("mid_rst_fqpred", fq_pred_pc, 32'h0);
    check_eq("mid_rst_addr", icache_req_addr, 32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
